// File: rtl/fix2flt_seq_if.sv
// Handshake and data-memory bus of the fixed-to-half-float converter.
// master: the converter side. slave: the test bench / memory side.
interface fix2flt_seq_if;
    logic       start;
    logic       done;
    logic [7:0] dm_addr;
    logic       dm_rd;
    logic       dm_wr;
    logic [7:0] dm_wdata;
    logic [7:0] dm_rdata;

    modport master (
        input  start,
        input  dm_rdata,
        output done,
        output dm_addr,
        output dm_rd,
        output dm_wr,
        output dm_wdata
    );

    modport slave (
        output start,
        output dm_rdata,
        input  done,
        input  dm_addr,
        input  dm_rd,
        input  dm_wr,
        input  dm_wdata
    );
endinterface

// File: rtl/fix2flt_seq.sv
// fix2flt_seq: sequential 8.8 two's-complement fixed point to IEEE-754 half
// converter. Reads the input word from data memory, normalizes one bit per
// cycle, rounds, and writes the half-float back, then pulses done.
// Optional macro ROUND_NEAREST_EN: round to nearest even (default: truncate).
module fix2flt_seq #(
    parameter logic [7:0] SRC_ADDR = 8'd0,
    parameter logic [7:0] DST_ADDR = 8'd2
) (
    input  logic            clk,
    input  logic            reset,
    fix2flt_seq_if.master   bus
);
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] RD_LO = 4'd1;
    localparam logic [3:0] RD_HI = 4'd2;
    localparam logic [3:0] NEG   = 4'd3;
    localparam logic [3:0] NORM  = 4'd4;
    localparam logic [3:0] ROUND = 4'd5;
    localparam logic [3:0] WR_LO = 4'd6;
    localparam logic [3:0] WR_HI = 4'd7;
    localparam logic [3:0] DONE  = 4'd8;

    logic [3:0]  state, state_n;
    logic        start_q;
    logic [15:0] x;
    logic [15:0] mag;
    logic [3:0]  s;
    logic        sign;
    logic [15:0] result;
    logic [15:0] neg_mag;
    logic [4:0]  exp_b, exp_r;
    logic [9:0]  mant_r;
    logic [15:0] rnd_res;

    // Magnitude of the captured word; 0x8000 maps to 0x8000 as unsigned.
    assign neg_mag = x[15] ? (~x + 16'd1) : x;

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_q && !bus.start) state_n = RD_LO;
            RD_LO:   state_n = RD_HI;
            RD_HI:   state_n = NEG;
            NEG:     state_n = ((neg_mag == 16'd0) || neg_mag[15]) ? ROUND : NORM;
            NORM:    if (mag[14]) state_n = ROUND;
            ROUND:   state_n = WR_LO;
            WR_LO:   state_n = WR_HI;
            WR_HI:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Exponent/mantissa assembly and rounding of the normalized magnitude.
    // A zero input skips NORM, so mag[15]==0 in ROUND identifies it.
    always_comb begin
        exp_b = 5'd22 - {1'b0, s};
`ifdef ROUND_NEAREST_EN
        begin
            logic        guard, sticky;
            logic [10:0] mant_inc;
            guard    = mag[4];
            sticky   = |mag[3:0];
            mant_inc = {1'b0, mag[14:5]} + {10'd0, guard & (sticky | mag[5])};
            if (mant_inc[10]) begin
                exp_r  = exp_b + 5'd1;
                mant_r = '0;
            end else begin
                exp_r  = exp_b;
                mant_r = mant_inc[9:0];
            end
        end
`else
        exp_r  = exp_b;
        mant_r = mag[14:5];
`endif
        rnd_res = mag[15] ? {sign, exp_r, mant_r} : '0;
    end

    // State, datapath and registered bus outputs (decoded from next state).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            x            <= '0;
            mag          <= '0;
            s            <= '0;
            sign         <= 1'b0;
            result       <= '0;
            bus.done     <= 1'b0;
            bus.dm_rd    <= 1'b0;
            bus.dm_wr    <= 1'b0;
            bus.dm_addr  <= '0;
            bus.dm_wdata <= '0;
        end else begin
            state   <= state_n;
            start_q <= bus.start;
            case (state)
                RD_LO: x[7:0]  <= bus.dm_rdata;
                RD_HI: x[15:8] <= bus.dm_rdata;
                NEG: begin
                    sign <= x[15];
                    mag  <= neg_mag;
                    s    <= '0;
                end
                NORM: begin
                    mag <= {mag[14:0], 1'b0};
                    s   <= s + 4'd1;
                end
                ROUND:   result <= rnd_res;
                default: ;
            endcase
            bus.done  <= (state_n == DONE);
            bus.dm_rd <= (state_n == RD_LO) || (state_n == RD_HI);
            bus.dm_wr <= (state_n == WR_LO) || (state_n == WR_HI);
            case (state_n)
                RD_LO: bus.dm_addr <= SRC_ADDR;
                RD_HI: bus.dm_addr <= SRC_ADDR + 8'd1;
                WR_LO: begin
                    bus.dm_addr  <= DST_ADDR;
                    bus.dm_wdata <= rnd_res[7:0];
                end
                WR_HI: begin
                    bus.dm_addr  <= DST_ADDR + 8'd1;
                    bus.dm_wdata <= result[15:8];
                end
                default: ;
            endcase
        end
    end
endmodule
